// File: rtl/exibidor_sequencia.sv
// Plays the stored sequence back on the LEDs: addresses 0..limite, T_ON lit then T_OFF dark each.
// Optional abort input enabled by defining EXIBIDOR_ABORTA_EN.
module exibidor_sequencia #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned T_ON   = 1000,
   parameter int unsigned T_OFF  = 500
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
`ifdef EXIBIDOR_ABORTA_EN
   input  logic              abortar,
`endif
   input  logic [ADDR_W-1:0] limite,
   input  logic [DATA_W-1:0] dado_mem,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] leds,
   output logic              exibindo,
   output logic              fim_exibicao,
   output logic [3:0]        db_estado
);

   localparam int unsigned T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TMR_W-1:0] TON_LAST  = TMR_W'(T_ON - 1);
   localparam logic [TMR_W-1:0] TOFF_LAST = TMR_W'(T_OFF - 1);

   typedef enum logic [3:0] {
      OCIOSO  = 4'h0,
      CARREGA = 4'h1,
      ACENDE  = 4'h2,
      APAGA   = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'hF
   } estado_t;

   estado_t           estado;
   logic [TMR_W-1:0]  timer;
   logic [ADDR_W-1:0] lim_r;
   logic [DATA_W-1:0] led_r;
   logic [ADDR_W-1:0] endereco_r;
   logic              exibindo_r;
   logic              fim_r;
   logic              aborta;
   logic              ocupado;

`ifdef EXIBIDOR_ABORTA_EN
   assign aborta = abortar;
`else
   assign aborta = 1'b0;
`endif

   assign ocupado = (estado == CARREGA) || (estado == ACENDE) ||
                    (estado == APAGA)   || (estado == PROXIMO);

   // Outputs are registered alongside the state: led_r only holds the word while lit,
   // and exibindo/fim are set on the transitions into their states.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado     <= OCIOSO;
         timer      <= '0;
         lim_r      <= '0;
         led_r      <= '0;
         endereco_r <= '0;
         exibindo_r <= 1'b0;
         fim_r      <= 1'b0;
      end else begin
         fim_r <= 1'b0;
         if (aborta && ocupado) begin
            estado     <= OCIOSO;
            led_r      <= '0;
            exibindo_r <= 1'b0;
         end else begin
            case (estado)
               OCIOSO: begin
                  led_r      <= '0;
                  exibindo_r <= 1'b0;
                  if (iniciar) begin
                     endereco_r <= '0;
                     lim_r      <= limite;
                     exibindo_r <= 1'b1;
                     estado     <= CARREGA;
                  end
               end
               CARREGA: begin
                  led_r  <= dado_mem;
                  timer  <= '0;
                  estado <= ACENDE;
               end
               ACENDE: begin
                  if (timer == TON_LAST) begin
                     timer  <= '0;
                     led_r  <= '0;
                     estado <= APAGA;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               APAGA: begin
                  if (timer == TOFF_LAST) begin
                     timer <= '0;
                     if (endereco_r == lim_r) begin
                        exibindo_r <= 1'b0;
                        fim_r      <= 1'b1;
                        estado     <= FIM;
                     end else begin
                        estado <= PROXIMO;
                     end
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               PROXIMO: begin
                  endereco_r <= endereco_r + 1'b1;
                  estado     <= CARREGA;
               end
               FIM: begin
                  estado <= OCIOSO;
               end
               default: begin
                  led_r      <= '0;
                  exibindo_r <= 1'b0;
                  estado     <= OCIOSO;
               end
            endcase
         end
      end
   end

   assign endereco     = endereco_r;
   assign leds         = led_r;
   assign exibindo     = exibindo_r;
   assign fim_exibicao = fim_r;
   assign db_estado    = estado;

endmodule

// File: doc/exibidor_sequencia.md
Name: exibidor_sequencia

Overview:
- Output-side counterpart of the game control unit. The control unit consumes player plays (jogada) and compares them against memory; this block plays the stored sequence back to the player on the LEDs.
- On `iniciar`, it walks memory addresses 0..`limite`. Each element's LED pattern is shown for T_ON cycles, followed by T_OFF dark cycles.
- When the walk completes, it pulses `fim_exibicao`. The game control unit uses that pulse to move from `inicia_sequencia` to waiting for plays.
- Memory is external, with asynchronous (combinational) read.

Parameters:
- ADDR_W, 4: width of `endereco` and `limite`.
- DATA_W, 4: width of a memory word and of `leds`.
- T_ON, 1000: LED-on cycles per element. Must be >= 1; 1 kHz clock gives 1 s.
- T_OFF, 500: LED-off cycles after each element. Must be >= 1.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- iniciar  in  1  start request; sampled only in OCIOSO
- limite  in  ADDR_W  index of last element to show (inclusive); captured on accept
- dado_mem  in  DATA_W  memory word at `endereco` (combinational read)
- endereco  out  ADDR_W  memory address being shown
- leds  out  DATA_W  LED drive; 0 = all off
- exibindo  out  1  high while the sequence is being played
- fim_exibicao  out  1  one-cycle pulse at end of playback
- db_estado  out  4  current state code, for debug

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset (checked on the rising edge, overrides everything, including mid-playback):
  - State goes to OCIOSO.
  - `endereco`=0, `leds`=0, `exibindo`=0, `fim_exibicao`=0.
  - Timer=0, latched limite=0, LED register=0.
- Registers:
  - Timer: wide enough for max(T_ON, T_OFF).
  - `lim_r` (ADDR_W): latched limite.
  - `led_r` (DATA_W): captured memory word.
  - `endereco` register.
- States and db_estado codes:
  - OCIOSO (0):
    - `leds`=0.
    - If `iniciar`=1: `endereco`<=0, `lim_r`<=`limite`, go to CARREGA.
    - Otherwise stay; `endereco` holds its last value.
  - CARREGA (1): `led_r`<=`dado_mem`, timer<=0, go to ACENDE. `leds`=0 in this cycle.
  - ACENDE (2):
    - `leds`=`led_r`; timer increments.
    - When timer==T_ON-1: timer<=0, go to APAGA.
  - APAGA (3):
    - `leds`=0; timer increments.
    - When timer==T_OFF-1: go to FIM if `endereco`==`lim_r`, else to PROXIMO.
  - PROXIMO (4): `endereco`<=`endereco`+1, go to CARREGA.
  - FIM (F):
    - `fim_exibicao`=1 for exactly this cycle.
    - Go to OCIOSO; `endereco` holds `lim_r`.
  - Any other code: go to OCIOSO.
- Output decoding:
  - All outputs are Moore (decoded from state and registers only).
  - `exibindo`=1 in CARREGA, ACENDE, APAGA and PROXIMO.
- Timing:
  - Each element takes T_ON+T_OFF+2 cycles: the CARREGA cycle, T_ON cycles in ACENDE, T_OFF cycles in APAGA, plus one cycle in PROXIMO or FIM.
  - For N = `lim_r`+1 elements, from the first CARREGA cycle through the FIM cycle inclusive, playback lasts N*(T_ON+T_OFF+2) cycles.
  - The first CARREGA follows the accepting edge.
- Boundaries:
  - `iniciar` while busy is ignored; `limite` changes while busy are ignored.
  - `limite`=0 shows exactly one element (address 0).
  - `limite`=2^ADDR_W-1 shows every address; `endereco` never wraps, because FIM is taken first.
  - `dado_mem`=0 is a valid element: a fully dark ACENDE period.
  - `iniciar` held high through FIM starts a new playback on the cycle after returning to OCIOSO.

Optional Feature:
- Macro: EXIBIDOR_ABORTA_EN.
- When defined, the block adds input port `abortar` (1 bit).
  - If `abortar`=1 in CARREGA, ACENDE, APAGA or PROXIMO: next state is OCIOSO.
  - `leds` goes to 0 and `exibindo` goes to 0; no `fim_exibicao` pulse; `endereco` holds its value.
  - If `abortar` and `iniciar` are both high in OCIOSO, `iniciar` wins.
  - `reset` has priority over `abortar`.
- When not defined, the port does not exist and playback always runs to FIM.

Test Plan:
- All scenarios use T_ON=4, T_OFF=2.
- Reset mid-ACENDE while showing element 2 -> next cycle: state 0, `leds`=0, `endereco`=0, `exibindo`=0, no `fim_exibicao` pulse.
- Memory {1,2,4,8}, `limite`=3, `iniciar` pulsed one cycle -> `leds` shows 1,2,4,8, each for exactly 4 cycles with 2 dark cycles between; `fim_exibicao` pulses once, 32 cycles after the first CARREGA cycle (on the 32nd cycle inclusive); `endereco` ends at 3.
- `limite`=0, mem[0]=4'b0100 -> one 4-cycle flash of 0100; `fim_exibicao` on the 8th cycle from CARREGA; no PROXIMO visited.
- Pulse `iniciar` during ACENDE, and change `limite` from 3 to 1 mid-playback -> playback unaffected; all 4 elements still shown; a single `fim_exibicao`.
- `limite`=15, mem[i]=i -> 16 elements shown; `endereco` stops at 15 with no wrap; `fim_exibicao` at cycle 128.
- With EXIBIDOR_ABORTA_EN defined, `abortar`=1 during element 1's APAGA -> next cycle state 0, `leds`=0, no `fim_exibicao`; a subsequent `iniciar` restarts playback from `endereco`=0.
